// File: rtl/comb_chk_pkg.sv
// ---------------------------------------------------------------------------
// comb_chk_pkg
// Shared definitions for the combinational vector checker.
//   state_t   : checker FSM states
//   VEC_W     : width of a stimulus vector {a,b,c}
//   VEC_LAST  : last vector of one sweep
//   exp_x()   : reference function x = (a ^ b) | c
// Optional feature macro used by the checker top: STOP_ON_FAIL_EN
// ---------------------------------------------------------------------------
package comb_chk_pkg;

  // Checker FSM states
  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam int          VEC_W    = 3;
  localparam logic [2:0]  VEC_LAST = 3'd7;

  // Golden reference for the block under test
  function automatic logic exp_x(input logic a, input logic b, input logic c);
    return (a ^ b) | c;
  endfunction

endpackage

// File: rtl/comb_golden_model.sv
// ---------------------------------------------------------------------------
// comb_golden_model
// Purely combinational reference model. Kept as its own module so a
// different 3-input gate can be checked by swapping this file alone,
// without touching the checker FSM.
// Ports:
//   a, b, c : input  stimulus bits (vector bits 2,1,0)
//   x_exp   : output expected response of the block under test
// ---------------------------------------------------------------------------
module comb_golden_model
  import comb_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x_exp
);

  assign x_exp = exp_x(a, b, c);

endmodule

// File: rtl/comb_vec_checker.sv
// ---------------------------------------------------------------------------
// comb_vec_checker
// On-chip stimulus driver / response monitor for a 3-input combinational
// block. On start it walks all 8 vectors {a,b,c} NUM_PASSES times, waits
// SETTLE cycles after driving each vector, samples x_in and compares it with
// the golden model. Reports a saturating mismatch count and the first
// failing vector.
//
// Parameters:
//   NUM_PASSES : full 8-vector sweeps per run (>=1)
//   SETTLE     : idle cycles between driving a vector and sampling (>=0)
//   ERR_W      : width of the saturating mismatch counter
//
// Ports:
//   clk              : input  system clock, rising edge
//   rst_n            : input  synchronous active-low reset
//   start            : input  single-cycle run request (ignored while busy)
//   a, b, c          : output stimulus bits (vector bits 2,1,0)
//   x_in             : input  response of the block under test
//   busy             : output run in progress
//   done             : output run complete, held until next accepted start
//   pass             : output valid with done, 1 iff err_count == 0
//   err_count        : output saturating mismatch count
//   first_fail_vec   : output {a,b,c} of the first mismatch
//   first_fail_valid : output first_fail_vec holds a captured mismatch
//
// Optional feature (macro STOP_ON_FAIL_EN): the first mismatch ends the run
// immediately with a/b/c holding the failing vector.
// ---------------------------------------------------------------------------
module comb_vec_checker
  import comb_chk_pkg::*;
#(
  parameter int NUM_PASSES = 1,
  parameter int SETTLE     = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             x_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  state_t              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [VEC_W-1:0]    abc_q, abc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [VEC_W-1:0]    ffvec_q, ffvec_d;
  logic                ffvalid_q, ffvalid_d;

  logic x_exp;
  logic mismatch;
  logic last_vec;
  logic finish;

  // Reference is evaluated on the registered stimulus, i.e. exactly what
  // the block under test is currently seeing.
  comb_golden_model u_golden (
    .a     (abc_q[2]),
    .b     (abc_q[1]),
    .c     (abc_q[0]),
    .x_exp (x_exp)
  );

  // Next-state and next-output computation for the whole checker.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    wait_cnt_d = wait_cnt_q;
    abc_d      = abc_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ffvec_d    = ffvec_q;
    ffvalid_d  = ffvalid_q;

    mismatch = (x_in != x_exp);
    last_vec = (vec_q == VEC_LAST) && (pass_cnt_q == PASS_LAST);
    finish   = 1'b0;

    case (state_q)
      // DONE accepts a new start exactly like IDLE; a/b/c are left alone so
      // they keep showing the last driven vector.
      IDLE, DONE: begin
        if (start) begin
          state_d    = DRIVE;
          vec_d      = '0;
          pass_cnt_d = '0;
          err_d      = '0;
          ffvec_d    = '0;
          ffvalid_d  = 1'b0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end

      DRIVE: begin
        abc_d      = vec_q;
        wait_cnt_d = '0;
        state_d    = (SETTLE > 0) ? WAIT : SAMPLE;
      end

      WAIT: begin
        if (wait_cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!ffvalid_q) begin
            ffvalid_d = 1'b1;
            ffvec_d   = abc_q;
          end
        end
`ifdef STOP_ON_FAIL_EN
        finish = last_vec || mismatch;
`else
        finish = last_vec;
`endif
        if (finish) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          // vec is 3 bits wide so 7 -> 0 wraps on its own
          vec_d   = vec_q + 3'd1;
          state_d = DRIVE;
          if (vec_q == VEC_LAST) begin
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Single state register; reset aborts any run and drops every output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      pass_cnt_q <= '0;
      wait_cnt_q <= '0;
      abc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffvec_q    <= '0;
      ffvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      abc_q      <= abc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ffvec_q    <= ffvec_d;
      ffvalid_q  <= ffvalid_d;
    end
  end

  assign a                = abc_q[2];
  assign b                = abc_q[1];
  assign c                = abc_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_comb_vec_checker.sv
// ---------------------------------------------------------------------------
// tb_comb_vec_checker
// Directed bench for comb_vec_checker. Three checker instances share clock,
// reset and start:
//   u_dut1 : defaults (NUM_PASSES=1, SETTLE=1, ERR_W=8)
//   u_dut2 : NUM_PASSES=2, SETTLE=0, ERR_W=8
//   u_dut3 : NUM_PASSES=2, SETTLE=0, ERR_W=2
// Each checker looks at its own behavioural block under test whose
// behaviour is selected by 'mode' (0 correct, 1 stuck-0, 2 stuck-1, 3 OR).
// Expected values honour STOP_ON_FAIL_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_comb_vec_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   mode;

  logic a1, b1, c1, x1, busy1, done1, pass1, ffv1;
  logic a2, b2, c2, x2, busy2, done2, pass2, ffv2;
  logic a3, b3, c3, x3, busy3, done3, pass3, ffv3;
  logic [7:0] err1, err2;
  logic [1:0] err3;
  logic [2:0] ffvec1, ffvec2, ffvec3;

  int total = 0;
  int bad   = 0;

  int cyc1, cyc2, cyc3;

  always #5 clk = ~clk;

  // Behavioural block under test, selected by mode
  function automatic logic modelX(input int m, input logic a, input logic b, input logic c);
    case (m)
      0:       return (a ^ b) | c;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a | b | c;
    endcase
  endfunction

  assign x1 = modelX(mode, a1, b1, c1);
  assign x2 = modelX(mode, a2, b2, c2);
  assign x3 = modelX(mode, a3, b3, c3);

  comb_vec_checker u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a1), .b(b1), .c(c1), .x_in(x1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffvec1), .first_fail_valid(ffv1)
  );

  comb_vec_checker #(.NUM_PASSES(2), .SETTLE(0), .ERR_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a2), .b(b2), .c(c2), .x_in(x2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_vec(ffvec2), .first_fail_valid(ffv2)
  );

  comb_vec_checker #(.NUM_PASSES(2), .SETTLE(0), .ERR_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a3), .b(b3), .c(c3), .x_in(x3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_vec(ffvec3), .first_fail_valid(ffv3)
  );

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start, then count edges until each instance raises done.
  // midStartAt > 0 re-pulses start while the run is busy.
  task automatic applyStimulus(input int midStartAt, output int c1o, output int c2o, output int c3o);
    c1o = -1; c2o = -1; c3o = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (done1 && c1o < 0) c1o = n;
      if (done2 && c2o < 0) c2o = n;
      if (done3 && c3o < 0) c3o = n;
      if (c1o >= 0 && c2o >= 0 && c3o >= 0) break;
      if (n == midStartAt) start = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_abc",   {a1, b1, c1}, 0);
    checkOutput("rst_busy",  busy1, 0);
    checkOutput("rst_done",  done1, 0);
    checkOutput("rst_pass",  pass1, 0);
    checkOutput("rst_err",   err1, 0);
    checkOutput("rst_ffv",   {ffv1, ffvec1}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct block under test
    mode = 0;
    applyStimulus(0, cyc1, cyc2, cyc3);
    checkOutput("ok_cycles", cyc1, 24);
    checkOutput("ok_pass",   pass1, 1);
    checkOutput("ok_err",    err1, 0);
    checkOutput("ok_ffv",    ffv1, 0);
    checkOutput("ok_busy",   busy1, 0);
    checkOutput("ok_abc",    {a1, b1, c1}, 7);
    checkOutput("ok_cyc2",   cyc2, 32);

    // Stuck-at-0
    mode = 1;
    applyStimulus(0, cyc1, cyc2, cyc3);
`ifdef STOP_ON_FAIL_EN
    checkOutput("s0_cycles", cyc1, 6);
    checkOutput("s0_err",    err1, 1);
    checkOutput("s0_abc",    {a1, b1, c1}, 1);
    checkOutput("s0_cyc2",   cyc2, 4);
    checkOutput("s0_err2",   err2, 1);
    checkOutput("s0_err3",   err3, 1);
`else
    checkOutput("s0_cycles", cyc1, 24);
    checkOutput("s0_err",    err1, 6);
    checkOutput("s0_abc",    {a1, b1, c1}, 7);
    checkOutput("s0_cyc2",   cyc2, 32);
    checkOutput("s0_err2",   err2, 12);
    checkOutput("s0_err3",   err3, 3);
`endif
    checkOutput("s0_ffvec",  ffvec1, 1);
    checkOutput("s0_ffv",    ffv1, 1);
    checkOutput("s0_pass",   pass1, 0);
    checkOutput("s0_pass3",  pass3, 0);

    // Stuck-at-1
    mode = 2;
    applyStimulus(0, cyc1, cyc2, cyc3);
`ifdef STOP_ON_FAIL_EN
    checkOutput("s1_err",    err1, 1);
    checkOutput("s1_cycles", cyc1, 3);
`else
    checkOutput("s1_err",    err1, 2);
    checkOutput("s1_cycles", cyc1, 24);
`endif
    checkOutput("s1_ffvec",  ffvec1, 0);
    checkOutput("s1_pass",   pass1, 0);

    // OR gate instead of (a^b)|c: differs only at 110
    mode = 3;
    applyStimulus(0, cyc1, cyc2, cyc3);
`ifdef STOP_ON_FAIL_EN
    checkOutput("or_cycles", cyc1, 21);
`else
    checkOutput("or_cycles", cyc1, 24);
`endif
    checkOutput("or_err",    err1, 1);
    checkOutput("or_ffvec",  ffvec1, 6);
    checkOutput("or_ffv",    ffv1, 1);

    // Start pulse while busy must not disturb the run
    mode = 0;
    applyStimulus(5, cyc1, cyc2, cyc3);
    checkOutput("mid_cycles", cyc1, 24);
    checkOutput("mid_pass",   pass1, 1);

    // Reset in the middle of a stuck-at-0 run
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`ifdef STOP_ON_FAIL_EN
    checkOutput("mr_err_pre", err1, 1);
`else
    checkOutput("mr_err_pre", err1, 2);
    checkOutput("mr_busy_pre", busy1, 1);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mr_all_zero",
                {a1, b1, c1, busy1, done1, pass1, ffv1, ffvec1, err1}, 0);

    // Start coincident with reset: reset wins
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rs_busy", busy1, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_busy", busy1, 0);
    checkOutput("idle_done", done1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
